// File: rtl/fll_lock_controller.sv
// rtl/fll_lock_controller.sv - FLL trim controller: DCO-cycle measurement, coarse/fine thermometer trim steering, lock detect
// Optional lock detector built only when FLL_LOCK_DETECT_EN is defined; otherwise locked is tied low.
module fll_lock_controller #(
   parameter int TRIM_BITS  = 26,
   parameter int DIV_BITS   = 5,
   parameter int TRIM_INIT  = 13,
   parameter int COARSE_THR = 2,
   parameter int LOCK_TOL   = 1,
   parameter int LOCK_CNT   = 4,
   localparam int TW        = $clog2(TRIM_BITS + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 osc,
   input  logic [DIV_BITS-1:0]  div,
   input  logic                 dco,
   input  logic                 hold,
   input  logic [TRIM_BITS-1:0] ext_trim,
   output logic [TRIM_BITS-1:0] trim,
   output logic [TW-1:0]        tcode,
   output logic                 locked
);

   localparam int CW = DIV_BITS + 1;
   localparam int EW = DIV_BITS + 2;
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0]        CNT_MAX = {CW{1'b1}};
   localparam logic signed [EW-1:0] THR_P   = EW'(COARSE_THR);
   localparam logic signed [EW-1:0] THR_N   = -THR_P;
   localparam logic signed [EW-1:0] TOL_P   = EW'(LOCK_TOL);
   localparam logic signed [EW-1:0] TOL_N   = -TOL_P;
   localparam logic signed [TW+1:0] TMAX    = (TW+2)'(TRIM_BITS);

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t                 state, state_next;
   logic                   osc_s1, osc_s2, osc_s3, osc_rise;
   logic [CW-1:0]          cnt, cnt_inc, snap;
   logic                   upd;
   logic                   count_en, reload_tcode, capture, do_update;
   logic signed [EW-1:0]   err;
   logic                   snap_sat, in_tol;
   logic signed [2:0]      step;
   logic signed [TW+1:0]   tsum;
   logic [TW-1:0]          tcode_step;
   logic [TRIM_BITS-1:0]   therm;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         osc_s1   <= 1'b0;
         osc_s2   <= 1'b0;
         osc_s3   <= 1'b0;
         osc_rise <= 1'b0;
      end else begin
         osc_s1   <= osc;
         osc_s2   <= osc_s1;
         osc_s3   <= osc_s2;
         osc_rise <= osc_s2 & ~osc_s3;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (!enable || dco) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = ARM;
            ARM:     if (osc_rise) state_next = RUN;
            default: state_next = RUN;
         endcase
      end
   end

   always_comb begin
      count_en     = (state != IDLE);
      reload_tcode = (state == IDLE) && (state_next == ARM);
      capture      = (state == RUN) && osc_rise;
      do_update    = (state == RUN) && upd;
   end

   // snap counts the osc_rise cycle itself, so it reads one more than the clocks between rises
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         snap <= '0;
         upd  <= 1'b0;
      end else begin
         upd <= capture;
         if (!count_en) begin
            cnt <= '0;
         end else if (osc_rise) begin
            cnt  <= CW'(1);
            snap <= cnt_inc;
         end else begin
            cnt <= cnt_inc;
         end
      end
   end

   assign err      = $signed({1'b0, snap}) - $signed({2'b00, div});
   assign snap_sat = (snap == CNT_MAX);
   assign in_tol   = !snap_sat && (err >= TOL_N) && (err <= TOL_P);

   always_comb begin
      step = 3'sd0;
      if (snap_sat || err > THR_P) step = 3'sd2;
      else if (err > 0)            step = 3'sd1;
      else if (err < THR_N)        step = -3'sd2;
      else if (err < 0)            step = -3'sd1;
      tsum = $signed({2'b00, tcode}) + $signed({{(TW-1){step[2]}}, step});
      if (tsum < 0)          tcode_step = '0;
      else if (tsum > TMAX)  tcode_step = TW'(TRIM_BITS);
      else                   tcode_step = tsum[TW-1:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                  tcode <= TW'(TRIM_INIT);
      else if (reload_tcode)                      tcode <= TW'(TRIM_INIT);
      else if (do_update && !hold && div != '0)   tcode <= tcode_step;
   end

`ifdef FLL_LOCK_DETECT_EN
   logic [LW-1:0] lock_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                   lock_cnt <= '0;
      else if (state_next == IDLE) lock_cnt <= '0;
      else if (do_update) begin
         if (!in_tol)                          lock_cnt <= '0;
         else if (lock_cnt != LW'(LOCK_CNT))   lock_cnt <= lock_cnt + LW'(1);
      end
   end

   assign locked = (lock_cnt == LW'(LOCK_CNT));
`else
   logic [LW-1:0] unused_lock_cnt;
   logic          unused_in_tol;
   assign unused_lock_cnt = LW'(LOCK_CNT);
   assign unused_in_tol   = in_tol;
   assign locked          = 1'b0;
`endif

   always_comb begin
      therm = '0;
      for (int i = 0; i < TRIM_BITS; i++) therm[i] = (i < int'(tcode));
   end

   assign trim = dco ? ext_trim : therm;

endmodule
